normshift_iter: RTL and testbench
=================================

# normshift_iter

Iterative left-normalization shifter. Accepts a WIDTH-bit operand and shifts it left until its MSB is 1. Each shift cycle moves the operand by up to STEP positions. The block returns the normalized value together with the total shift count. It is the consumer end of leading-zero counting in the FP datapath: it trades area for latency in multi-cycle divide/sqrt and conversion paths, where a full-width LZC plus a barrel shifter is too costly.

## Interface
- WIDTH, default 64: operand width; WIDTH >= 1.
- STEP, default 8: maximum shift per cycle; power of 2, 1 <= STEP <= WIDTH.
- Widths below: CW = $clog2(WIDTH+1).

Ports:
- clk  in  1: clock. One clock domain only.
- reset  in  1: asynchronous, active-high reset.
- InValid  in  1: operand offered.
- InReady  out  1: block can accept an operand. High only in IDLE.
- In  in  WIDTH: operand.
- OutValid  out  1: result available. High only in DONE.
- OutReady  in  1: consumer accepts the result.
- Norm  out  WIDTH: normalized operand. MSB is 1 unless Zero is set.
- ShiftCnt  out  CW: total left shift applied; equals the operand's leading-zero count.
- Zero  out  1: operand was all zeros.

## Operation
- States: IDLE, SHIFT, DONE. Internal registers: value (WIDTH bits), count (CW bits), zero (1 bit).
- Norm, ShiftCnt and Zero are driven directly from value, count and zero in every state. They are guaranteed meaningful only while OutValid=1.

IDLE:
- InReady=1.
- On InValid & InReady: capture In into value, clear count, then branch:
  - In == 0: zero=1, count=WIDTH, value=0, go to DONE.
  - In[WIDTH-1]=1: zero=0, go to DONE (count=0).
  - Otherwise: zero=0, go to SHIFT.

SHIFT:
- Each cycle, examine the window value[WIDTH-1 -: STEP].
  - Window all zero: shift by s=STEP.
  - Otherwise: s = leading-zero count of the window (0 < s < STEP).
- Update value <= value << s, zero-filled from the LSB.
- Update count <= count + s. Count never exceeds WIDTH-1 in this state, so it never wraps.
- Go to DONE when the shifted value has its MSB set; otherwise stay in SHIFT.
- An operand with lz leading zeros (1 <= lz <= WIDTH-1) spends exactly ceil(lz/STEP) cycles in SHIFT.

DONE:
- OutValid=1. Outputs are held stable while OutReady=0.
- On OutReady: go to IDLE.
- InReady=0, so the block cannot accept a new operand in the cycle the result is consumed.

General rules:
- InValid is ignored outside IDLE. In is sampled only on the accept edge.
- STEP == WIDTH degenerates to a single SHIFT cycle for any nonzero operand whose MSB is clear.

## Timing
- Reset, effective immediately and independent of clk:
  - state=IDLE, value=0, count=0, zero=0.
  - Outputs: InReady=1, OutValid=0, Norm=0, ShiftCnt=0, Zero=0.
- Reset in SHIFT or DONE aborts the operation. No result is produced.
- Accept at edge T:
  - Zero operand, or MSB already set: OutValid=1 in cycle T+1.
  - Otherwise: OutValid=1 in cycle T+1+ceil(lz/STEP).
- Throughput: the next accept occurs no earlier than 1 cycle after the output handshake edge.
- All state and outputs are registered. There is no combinational path from InValid or OutReady to any output.

## Test plan
- WIDTH=64, STEP=8, In=0 -> OutValid at T+1, Zero=1, ShiftCnt=64, Norm=0.
- In=64'h8000_0000_0000_0001 -> OutValid at T+1, ShiftCnt=0, Norm unchanged, Zero=0.
- In=64'h0000_0000_0000_0001 (lz=63) -> 8 SHIFT cycles, OutValid at T+9, Norm=64'h8000_0000_0000_0000, ShiftCnt=63.
- In=64'h0080_0000_0000_0000 (lz=8) -> 1 SHIFT cycle, OutValid at T+2, ShiftCnt=8, Norm=64'h8000_0000_0000_0000. Repeat with lz=16 -> 2 SHIFT cycles, OutValid at T+3.
- Backpressure: hold OutReady=0 for 5 cycles in DONE -> OutValid, Norm and ShiftCnt stay stable; InReady=0 and InValid pulses are ignored. Raise OutReady -> IDLE next cycle, InReady=1.
- Assert reset mid-SHIFT, between clock edges, on a lz=63 operand -> immediately InReady=1, OutValid=0, all outputs 0. The next operand 64'h1 yields ShiftCnt=63 with correct latency.
- Randomized check: random In, STEP in {1,2,8,64} -> ShiftCnt equals the reference leading-zero count, Norm == In << ShiftCnt, latency matches the Timing rules.

Source files
------------

// File: rtl/normshift_iter.sv
// Iterative left-normalization shifter: shifts an operand left by up to STEP
// bits per cycle until its MSB is set, reporting the total shift applied.
//
// state | meaning
// IDLE  | waiting for an operand, InReady=1
// SHIFT | normalizing, up to STEP positions per cycle
// DONE  | result presented, OutValid=1 until OutReady
module normshift_iter #(
    parameter  int WIDTH = 64,
    parameter  int STEP  = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Norm,
    output logic [CW-1:0]    ShiftCnt,
    output logic             Zero
);

    localparam int SW = $clog2(STEP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] value;
    logic [CW-1:0]    count;
    logic             zero;

    logic             accept;
    logic [STEP-1:0]  window;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] shifted;

    // Leading zeros of the top window; an all-zero window yields STEP.
    function automatic logic [SW-1:0] win_lzc(input logic [STEP-1:0] w);
        logic [SW-1:0] r;
        r = SW'(STEP);
        for (int i = 0; i < STEP; i++) begin
            if (w[i]) begin
                r = SW'(STEP - 1 - i);
            end
        end
        return r;
    endfunction

    assign accept  = InValid && (state == IDLE);
    assign window  = value[WIDTH-1 -: STEP];
    assign shamt   = win_lzc(window);
    assign shifted = value << shamt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (InValid) begin
                    if ((In == '0) || In[WIDTH-1]) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (shifted[WIDTH-1]) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        InReady  = (state == IDLE);
        OutValid = (state == DONE);
        Norm     = value;
        ShiftCnt = count;
        Zero     = zero;
    end

    // Datapath registers; they only move on accept or while shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
            count <= '0;
            zero  <= 1'b0;
        end else if (accept) begin
            value <= In;
            count <= '0;
            zero  <= 1'b0;
            if (In == '0) begin
                zero  <= 1'b1;
                count <= CW'(WIDTH);
            end
        end else if (state == SHIFT) begin
            value <= shifted;
            count <= count + CW'(shamt);
        end
    end

endmodule

// File: tb/tb_normshift_iter.sv
// Bench for normshift_iter: directed cases plus randomized operands on four
// instances (STEP 8, 1, 2, 64) checked against a leading-zero reference.
module tb_normshift_iter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   inval;
    logic [3:0]   outready;
    logic [W-1:0] din [4];
    wire  [3:0]   inready;
    wire  [3:0]   outvalid;
    wire  [3:0]   zero;
    wire  [W-1:0] norm [4];
    wire  [6:0]   cnt [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        normshift_iter #(
            .WIDTH(W),
            .STEP (g == 0 ? 8 : (g == 1 ? 1 : (g == 2 ? 2 : 64)))
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .InValid (inval[g]),
            .InReady (inready[g]),
            .In      (din[g]),
            .OutValid(outvalid[g]),
            .OutReady(outready[g]),
            .Norm    (norm[g]),
            .ShiftCnt(cnt[g]),
            .Zero    (zero[g])
        );
    end

    function automatic int step_of(input int k);
        case (k)
            0: return 8;
            1: return 1;
            2: return 2;
            default: return 64;
        endcase
    endfunction

    function automatic int ref_lz(input logic [W-1:0] v);
        int n = 0;
        while (n < W && v[W-1-n] == 1'b0) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int k, input logic [W-1:0] v, input int hold,
                          input bit pulse, input string tag);
        int lz, stp, lat, n;
        logic [W-1:0] en;
        stp = step_of(k);
        lz  = ref_lz(v);
        lat = (lz == 0 || lz == W) ? 1 : 1 + (lz + stp - 1) / stp;
        en  = (lz == W) ? '0 : (v << lz);
        @(negedge clk);
        chk({tag, " inready_idle"}, inready[k], 1);
        din[k]   = v;
        inval[k] = 1'b1;
        @(posedge clk);
        #1;
        inval[k] = 1'b0;
        din[k]   = ~v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!outvalid[k] && n < 200);
        chk({tag, " latency"}, n, lat);
        chk({tag, " norm"}, norm[k], en);
        chk({tag, " shiftcnt"}, cnt[k], lz);
        chk({tag, " zero"}, zero[k], (lz == W));
        chk({tag, " inready_done"}, inready[k], 0);
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                inval[k] = 1'b1;
                din[k]   = W'(i) + 64'h1;
            end
            @(negedge clk);
            chk({tag, " hold_valid"}, outvalid[k], 1);
            chk({tag, " hold_norm"}, norm[k], en);
            chk({tag, " hold_cnt"}, cnt[k], lz);
            chk({tag, " hold_inready"}, inready[k], 0);
        end
        inval[k]    = 1'b0;
        outready[k] = 1'b1;
        @(negedge clk);
        outready[k] = 1'b0;
        chk({tag, " consumed_valid"}, outvalid[k], 0);
        chk({tag, " consumed_inready"}, inready[k], 1);
    endtask

    initial begin
        logic [W-1:0] r;
        reset    = 1'b1;
        inval    = '0;
        outready = '0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        #3;
        chk("rst inready", inready[0], 1);
        chk("rst outvalid", outvalid[0], 0);
        chk("rst norm", norm[0], 0);
        chk("rst cnt", cnt[0], 0);
        chk("rst zero", zero[0], 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(0, 64'h0, 0, 0, "zero");
        run_op(0, 64'h8000_0000_0000_0001, 0, 0, "msb_set");
        run_op(0, 64'h0000_0000_0000_0001, 0, 0, "lz63");
        run_op(0, 64'h0080_0000_0000_0000, 0, 0, "lz8");
        run_op(0, 64'h0000_8000_0000_0000, 0, 0, "lz16");
        run_op(0, 64'h0000_0123_4567_89ab, 5, 1, "backpressure");
        run_op(3, 64'h0000_0000_0000_0003, 0, 0, "step64");
        run_op(1, 64'h0000_0000_0000_0010, 0, 0, "step1");

        // Asynchronous reset in the middle of SHIFT, between clock edges.
        @(negedge clk);
        din[0]   = 64'h1;
        inval[0] = 1'b1;
        @(posedge clk);
        #1;
        inval[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst inready", inready[0], 1);
        chk("midrst outvalid", outvalid[0], 0);
        chk("midrst norm", norm[0], 0);
        chk("midrst cnt", cnt[0], 0);
        chk("midrst zero", zero[0], 0);
        @(negedge clk);
        reset = 1'b0;
        run_op(0, 64'h1, 0, 0, "post_rst");

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 25; j++) begin
                r = {$urandom, $urandom};
                r = r >> $urandom_range(0, 64);
                run_op(k, r, $urandom_range(0, 2), 0, $sformatf("rand_s%0d", step_of(k)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
